mux_rr_arbiter: RTL and testbench
=================================

Name: mux_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the 3-input, 4-bit priority mux datapath.
- Shares one registered output channel between three requesters (ip1..ip3).
- Drives one-hot sel1/sel2/sel3 grants, not priority-encoded selects, and caps burst length per grant.
- Output channel uses a valid/ready handshake toward the downstream consumer.

Parameters:
- DATA_W, 4, width of each requester data bus and of out_data.
- MAX_BURST, 4, max beats accepted from one requester per grant (legal range 1..15).

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous reset, active-high.
- req  input  3  request per requester; bit0=ip1, bit1=ip2, bit2=ip3.
- ip1  input  DATA_W  requester 1 data.
- ip2  input  DATA_W  requester 2 data.
- ip3  input  DATA_W  requester 3 data.
- sel1  output  1  grant to requester 1.
- sel2  output  1  grant to requester 2.
- sel3  output  1  grant to requester 3.
- beat_ack  output  1  granted requester's data captured this cycle.
- out_valid  output  1  out_data holds an unconsumed beat.
- out_data  output  DATA_W  registered selected data.
- out_ready  input  1  downstream accepts out_data when out_valid && out_ready.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset values: state=IDLE, sel1..sel3=0, beat_ack=0, out_valid=0, out_data=0, rr_ptr=0 (requester 1 highest priority), beat_cnt=0.
- States: IDLE, GRANT.
- IDLE:
  - grants all 0.
  - If req!=0, pick the first set bit at or after rr_ptr, wrapping 2->0.
  - Register the one-hot grant and go to GRANT next cycle.
- GRANT:
  - Capture condition: req[g] && (!out_valid || out_ready), where g is the granted index.
  - On capture: out_data<=ip[g], out_valid<=1, beat_ack=1 (combinational, same cycle), beat_cnt++.
  - Latency: ip[g] is sampled at the capture edge and visible on out_data the next cycle.
- Release, from GRANT to IDLE next cycle:
  - Occurs when req[g]==0, or when a capture makes beat_cnt reach MAX_BURST.
  - On release: rr_ptr<=(g+1) mod 3, beat_cnt<=0, grants drop next cycle.
- Arbitration gap: exactly one IDLE bubble between grants, even if other requests are pending.
- Output register:
  - If out_valid && out_ready && no capture, then out_valid<=0 and out_data holds its value.
  - Simultaneous accept and capture gives a back-to-back beat; out_valid stays 1.
- Backpressure: while out_valid && !out_ready there is no capture. beat_cnt, out_data and grant are frozen; the grant is still released if req[g] drops.
- Grant invariants:
  - sel1..sel3 are at most one-hot in every cycle.
  - Grants change only on the IDLE->GRANT or GRANT->IDLE transitions.
- Fairness: a continuously requesting requester is granted within 2 grant periods.
- Reset mid-burst: all state returns to its reset values on the next edge, and any pending out_valid beat is discarded.
- beat_cnt is 4 bits and never exceeds MAX_BURST.

Optional Feature:
- Macro: MUX_RR_ARBITER_ASSERT_EN.
- Defined, the block compiles in concurrent assertions on posedge clk, disabled iff rst:
  - grants one-hot-or-zero;
  - a capture implies out_data==ip[g] next cycle;
  - out_valid && !out_ready implies $stable(out_data) next cycle;
  - beat_cnt<=MAX_BURST;
  - starvation bound: req[i] held implies grant i within 3*(MAX_BURST+1)+2 cycles when out_ready is held 1.
- Undefined: no assertions, identical RTL behaviour.

Decomposition:
- Package mux_arb_pkg:
  - NUM_REQ=3;
  - state enum arb_state_e {IDLE, GRANT};
  - grant type logic [NUM_REQ-1:0];
  - function onehot_to_idx.
- Sub-module rr_pick: combinational round-robin picker.
  - Inputs: req[2:0], ptr[1:0].
  - Outputs: one-hot gnt[2:0], any.
- The top holds the FSM, counters and output register.

Test Plan:
- Reset then req=3'b001, ip1=4'hA, out_ready=1 -> sel1=1 at cycle 2, out_data=4'hA/out_valid=1 at cycle 3, 4 beats then sel1 drops (MAX_BURST=4).
- req=3'b111 held, out_ready=1 -> grant order sel1,sel2,sel3,sel1; each grant lasts 4 beats, with one zero-grant cycle between grants.
- Grant to ip2, out_ready=0 for 5 cycles, ip2 changes 3->7 -> out_data stays at first captured value 3, no beat_ack; after out_ready=1, captures resume with 7.
- req=3'b100 drops after 2 beats -> release after 2 captures, rr_ptr=0, next req=3'b011 grants sel1.
- rst asserted mid-burst with out_valid=1 -> next cycle all grants=0, out_valid=0, out_data=0, rr_ptr=0.
- With MUX_RR_ARBITER_ASSERT_EN defined, run 10k random req/out_ready cycles -> zero assertion failures.

Source files
------------

// File: rtl/mux_rr_arbiter_pkg.sv
// Shared types for the round-robin mux arbiter: requester count, FSM states,
// grant vector type and a one-hot to index helper.
package mux_arb_pkg;

    localparam int unsigned NUM_REQ = 3;

    typedef enum logic {IDLE, GRANT} arb_state_e;

    typedef logic [NUM_REQ-1:0] grant_t;

    // Index of the set bit in a one-hot grant; 0 when the grant is empty.
    function automatic logic [1:0] onehot_to_idx(input grant_t g);
        onehot_to_idx = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (g[i]) onehot_to_idx = 2'(i);
        end
    endfunction

endpackage

// File: rtl/mux_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first requester at or after
// ptr (wrapping 2->0) as a one-hot grant, plus an any-request flag.
module rr_pick
    import mux_arb_pkg::*;
(
    input  grant_t     req,
    input  logic [1:0] ptr,
    output grant_t     gnt,
    output logic       any
);

    logic found;

    assign any = |req;

    // Scan requesters starting from ptr and grant the first one found.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(32'(ptr) + k) % NUM_REQ]) begin
                gnt[(32'(ptr) + k) % NUM_REQ] = 1'b1;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter and sequencer sharing one registered valid/ready output
// channel between three requesters, with one-hot grants and a per-grant burst cap.
// Optional: define MUX_RR_ARBITER_ASSERT_EN to compile in concurrent assertions.
module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        req,
    input  logic [DATA_W-1:0] ip1,
    input  logic [DATA_W-1:0] ip2,
    input  logic [DATA_W-1:0] ip3,
    output logic              sel1,
    output logic              sel2,
    output logic              sel3,
    output logic              beat_ack,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    arb_state_e        state;
    grant_t            gnt_q;
    grant_t            pick_gnt;
    logic              pick_any;
    logic [1:0]        rr_ptr;
    logic [1:0]        gidx;
    logic [3:0]        beat_cnt;
    logic              req_g;
    logic              capture;
    logic              last_beat;
    logic              release_g;
    logic [DATA_W-1:0] sel_data;

    rr_pick u_pick (
        .req (req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    assign sel1      = gnt_q[0];
    assign sel2      = gnt_q[1];
    assign sel3      = gnt_q[2];
    assign gidx      = onehot_to_idx(gnt_q);
    assign req_g     = |(req & gnt_q);
    assign capture   = (state == GRANT) && req_g && (!out_valid || out_ready);
    assign last_beat = (beat_cnt == 4'(MAX_BURST - 1));
    assign release_g = (state == GRANT) && (!req_g || (capture && last_beat));
    assign beat_ack  = capture;

    // Data mux driven by the registered grant index.
    always_comb begin
        case (gidx)
            2'd1:    sel_data = ip2;
            2'd2:    sel_data = ip3;
            default: sel_data = ip1;
        endcase
    end

    // Arbitration FSM: grant in IDLE, count beats and release in GRANT.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            gnt_q    <= '0;
            rr_ptr   <= '0;
            beat_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt_q <= pick_gnt;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (capture) beat_cnt <= beat_cnt + 4'd1;
                    if (release_g) begin
                        state    <= IDLE;
                        gnt_q    <= '0;
                        beat_cnt <= '0;
                        rr_ptr   <= (gidx == 2'd2) ? 2'd0 : gidx + 2'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output register: load on capture, drain on accept, hold under backpressure.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (capture) begin
            out_valid <= 1'b1;
            out_data  <= sel_data;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef MUX_RR_ARBITER_ASSERT_EN
    localparam int STARVE = 3 * (MAX_BURST + 1) + 2;

    a_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(gnt_q));
    a_capture: assert property (@(posedge clk) disable iff (rst)
        capture |=> out_data == $past(sel_data));
    a_stall: assert property (@(posedge clk) disable iff (rst)
        (out_valid && !out_ready) |=> $stable(out_data));
    a_cnt: assert property (@(posedge clk) disable iff (rst) beat_cnt <= 4'(MAX_BURST));

    for (genvar i = 0; i < 3; i++) begin : g_starve
        a_starve: assert property (@(posedge clk) disable iff (rst)
            (req[i] && out_ready && !gnt_q[i]) [*STARVE] |=> gnt_q[i]);
    end
`endif

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed scoreboard bench for mux_rr_arbiter: stimulus pushes expected
// capture grants and output beats; a negedge monitor pops and compares them.
module tb_mux_rr_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [3:0] ip1, ip2, ip3;
    logic       sel1, sel2, sel3;
    logic       beat_ack;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;

    int total = 0;
    int bad   = 0;

    logic [2:0] cap_q[$];
    logic [3:0] data_q[$];
    logic [2:0] gpat[4];

    always #5 clk = ~clk;

    mux_rr_arbiter #(.DATA_W(4), .MAX_BURST(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .ip1       (ip1),
        .ip2       (ip2),
        .ip3       (ip3),
        .sel1      (sel1),
        .sel2      (sel2),
        .sel3      (sel3),
        .beat_ack  (beat_ack),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 3'b000;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    task automatic push(input logic [2:0] g, input logic [3:0] d, input int n);
        for (int i = 0; i < n; i++) begin
            cap_q.push_back(g);
            data_q.push_back(d);
        end
    endtask

    // Monitor: compare every capture grant and every accepted output beat.
    always @(negedge clk) begin
        if (!rst) begin
            chk("grant onehot0", 32'($onehot0({sel3, sel2, sel1})), 32'd1);
            if (beat_ack) begin
                if (cap_q.size() == 0) chk("unexpected capture", 32'(beat_ack), 32'd0);
                else chk("capture grant", 32'({sel3, sel2, sel1}), 32'(cap_q.pop_front()));
            end
            if (out_valid && out_ready) begin
                if (data_q.size() == 0) chk("unexpected beat", 32'(out_valid), 32'd0);
                else chk("out_data", 32'(out_data), 32'(data_q.pop_front()));
            end
        end
    end

    initial begin
        gpat[0] = 3'b001; gpat[1] = 3'b010; gpat[2] = 3'b100; gpat[3] = 3'b001;
        rst = 1'b1; req = 3'b000; out_ready = 1'b1;
        ip1 = 4'h0; ip2 = 4'h0; ip3 = 4'h0;
        repeat (2) tick();
        chk("reset grants", 32'({sel3, sel2, sel1}), 32'd0);
        chk("reset out_valid", 32'(out_valid), 32'd0);
        chk("reset out_data", 32'(out_data), 32'd0);
        chk("reset beat_ack", 32'(beat_ack), 32'd0);
        rst = 1'b0;

        // Single requester, full burst of 4.
        ip1 = 4'hA; req = 3'b001;
        push(3'b001, 4'hA, 4);
        tick();
        @(negedge clk);
        chk("t1 sel1 granted", 32'({sel3, sel2, sel1}), 32'b001);
        chk("t1 out_valid latency", 32'(out_valid), 32'd0);
        repeat (4) tick();
        chk("t1 grant released", 32'({sel3, sel2, sel1}), 32'd0);
        req = 3'b000;
        repeat (2) tick();

        // All requesting: rotation with one-cycle gaps.
        do_reset();
        ip1 = 4'h1; ip2 = 4'h2; ip3 = 4'h3; req = 3'b111;
        for (int g = 0; g < 4; g++) push(gpat[g], 4'(g % 3 + 1), 4);
        for (int k = 0; k < 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            chk("t2 grant sequence", 32'({sel3, sel2, sel1}),
                32'((k % 5 == 4) ? 3'b000 : gpat[k / 5]));
        end
        req = 3'b000;
        repeat (2) tick();

        // Backpressure on requester 2.
        do_reset();
        ip2 = 4'h3; req = 3'b010; out_ready = 1'b1;
        push(3'b010, 4'h3, 1);
        push(3'b010, 4'h7, 3);
        repeat (2) tick();
        out_ready = 1'b0; ip2 = 4'h7;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t3 stall beat_ack", 32'(beat_ack), 32'd0);
            chk("t3 stall out_data", 32'(out_data), 32'h3);
        end
        tick();
        out_ready = 1'b1;
        repeat (3) tick();
        req = 3'b000;
        repeat (2) tick();

        // Early release of requester 3, then requester 1 wins from ptr 0.
        do_reset();
        ip1 = 4'hA; ip3 = 4'hC; req = 3'b100;
        push(3'b100, 4'hC, 2);
        push(3'b001, 4'hA, 4);
        repeat (3) tick();
        req = 3'b011;
        tick();
        chk("t4 released", 32'({sel3, sel2, sel1}), 32'd0);
        tick();
        chk("t4 sel1 after wrap", 32'({sel3, sel2, sel1}), 32'b001);
        repeat (4) tick();
        req = 3'b000;
        repeat (2) tick();

        // Reset mid-burst with a pending beat (rr_ptr is 1 beforehand).
        ip1 = 4'h5; req = 3'b001; out_ready = 1'b0;
        cap_q.push_back(3'b001);
        repeat (2) tick();
        chk("t5 pending beat", 32'(out_valid), 32'd1);
        tick();
        rst = 1'b1;
        tick();
        chk("t5 reset grants", 32'({sel3, sel2, sel1}), 32'd0);
        chk("t5 reset out_valid", 32'(out_valid), 32'd0);
        chk("t5 reset out_data", 32'(out_data), 32'd0);
        rst = 1'b0; req = 3'b011; out_ready = 1'b1;
        tick();
        chk("t5 ptr reset grant", 32'({sel3, sel2, sel1}), 32'b001);
        req = 3'b000;
        repeat (3) tick();

        chk("captures outstanding", 32'(cap_q.size()), 32'd0);
        chk("beats outstanding", 32'(data_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
